a2d_intf: RTL and testbench

A2D_INTF -- requirements
Module: a2d_intf

---
 rtl/a2d_intf.sv | 87 ++++++++
 tb/tb_a2d_intf.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/a2d_intf.sv
// a2d_intf: SPI master that runs two 16-bit transactions per A2D conversion and keeps the second result
module a2d_intf (
    input  logic        clk,
    input  logic        rst,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] res,
    output logic        cnv_cmplt
);
    typedef enum logic [1:0] {IDLE, TXN1, GAP, TXN2} state_t;

    localparam logic [4:0] DIV_IDLE = 5'b10111;

    state_t      state_q, state_d;
    logic [4:0]  sclk_div_q, sclk_div_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [4:0]  gap_q, gap_d;
    logic [15:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic [2:0]  chnl_q, chnl_d;
    logic        ss_n_q, ss_n_d;
    logic [11:0] res_q, res_d;
    logic        cmplt_q, cmplt_d;
    logic        in_txn, rise_nxt, fall_nxt, done, start, gap_done, load;

    // next-state logic: sequencing, SPI clock divider, shift registers and result capture
    always_comb begin
        in_txn     = (state_q == TXN1) || (state_q == TXN2);
        rise_nxt   = in_txn && (sclk_div_q == 5'b01111);
        fall_nxt   = in_txn && (sclk_div_q == 5'b11111);
        done       = fall_nxt && (bit_cnt_q == 5'd16);
        start      = (state_q == IDLE) && strt_cnv && !cmplt_q;
        gap_done   = (state_q == GAP) && (gap_q == 5'd31);
        load       = start || gap_done;
        state_d    = start ? TXN1 :
                     (done && state_q == TXN1) ? GAP :
                     gap_done ? TXN2 :
                     (done && state_q == TXN2) ? IDLE : state_q;
        chnl_d     = start ? chnnl : chnl_q;
        tx_d       = load ? {2'b00, (start ? chnnl : chnl_q), 11'h000} :
                     (fall_nxt && bit_cnt_q < 5'd16) ? {tx_q[14:0], 1'b0} : tx_q;
        rx_d       = rise_nxt ? {rx_q[14:0], MISO} : rx_q;
        bit_cnt_d  = load ? 5'd0 : rise_nxt ? bit_cnt_q + 5'd1 : bit_cnt_q;
        sclk_div_d = (in_txn && !done) ? sclk_div_q + 5'd1 : DIV_IDLE;
        gap_d      = (state_q == GAP) ? gap_q + 5'd1 : 5'd0;
        ss_n_d     = load ? 1'b0 : done ? 1'b1 : ss_n_q;
        cmplt_d    = done && (state_q == TXN2);
        res_d      = cmplt_d ? rx_q[11:0] : res_q;
    end

    // state register with synchronous reset that aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sclk_div_q <= DIV_IDLE;
            bit_cnt_q  <= '0;
            gap_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            chnl_q     <= '0;
            ss_n_q     <= 1'b1;
            res_q      <= '0;
            cmplt_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sclk_div_q <= sclk_div_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_q      <= gap_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            chnl_q     <= chnl_d;
            ss_n_q     <= ss_n_d;
            res_q      <= res_d;
            cmplt_q    <= cmplt_d;
        end
    end

    assign SS_n      = ss_n_q;
    assign SCLK      = sclk_div_q[4];
    assign MOSI      = tx_q[15];
    assign res       = res_q;
    assign cnv_cmplt = cmplt_q;
endmodule

// File: tb/tb_a2d_intf.sv
// tb_a2d_intf: directed table-driven bench for a2d_intf with a behavioural ADC on MISO
module tb_a2d_intf;
    logic        clk = 1'b0;
    logic        rst;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        MISO;
    logic        SS_n, SCLK, MOSI, cnv_cmplt;
    logic [11:0] res;

    int checks = 0;
    int failures = 0;

    logic [15:0] w1, w2;
    bit          txn_sel;
    int          nfall;

    typedef struct {
        logic [2:0]  ch;
        logic [15:0] w1;
        logic [15:0] w2;
        logic [11:0] er;
        logic [15:0] em;
    } vec_t;

    vec_t tbl[4];

    a2d_intf dut (
        .clk(clk), .rst(rst), .strt_cnv(strt_cnv), .chnnl(chnnl), .MISO(MISO),
        .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .res(res), .cnv_cmplt(cnv_cmplt)
    );

    always #5 clk = ~clk;

    // ADC model: presents the MSB at select, then the next bit after every SCLK fall
    always @(negedge SS_n) begin
        nfall = 0;
        MISO = (txn_sel ? w2[15] : w1[15]);
    end

    always @(negedge SCLK) begin
        if (!SS_n && nfall < 16) begin
            MISO = txn_sel ? w2[15 - nfall] : w1[15 - nfall];
            nfall++;
        end
    end

    always @(posedge SS_n) txn_sel = ~txn_sel;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_conv(input vec_t v, input bit hold, input logic [11:0] prev);
        int t, t_r1, t_f2, t_r2, t_c, f0, f1, res_bad;
        logic [15:0] c0, c1;
        logic ps, pk, pm;
        w1 = v.w1;
        w2 = v.w2;
        txn_sel = 1'b0;
        chnnl = v.ch;
        strt_cnv = 1'b1;
        @(posedge clk); #1;
        strt_cnv = hold;
        chnnl = ~v.ch;
        chk("accept_ss_low", {15'd0, SS_n}, 16'd0);
        t = 0; t_r1 = 0; t_f2 = 0; t_r2 = 0; t_c = 0; f0 = 0; f1 = 0; res_bad = 0;
        c0 = '0; c1 = '0;
        ps = SS_n; pk = SCLK; pm = MOSI;
        while (t_c == 0 && t < 1300) begin
            @(posedge clk); #1;
            t++;
            if (pk && !SCLK) begin
                if (t_r1 == 0) begin f0++; c0 = {c0[14:0], pm}; end
                else begin f1++; c1 = {c1[14:0], pm}; end
            end
            if (!ps && SS_n) begin
                if (t_r1 == 0) t_r1 = t; else t_r2 = t;
            end
            if (ps && !SS_n) t_f2 = t;
            if (cnv_cmplt) t_c = t;
            else if (res !== prev) res_bad++;
            ps = SS_n; pk = SCLK; pm = MOSI;
        end
        chk("txn1_ss_low_len", t_r1[15:0], 16'd521);
        chk("gap_end", t_f2[15:0], 16'd553);
        chk("txn2_end", t_r2[15:0], 16'd1074);
        chk("cmplt_latency", t_c[15:0], 16'd1074);
        chk("txn1_falls", f0[15:0], 16'd16);
        chk("txn2_falls", f1[15:0], 16'd16);
        chk("txn1_mosi", c0, v.em);
        chk("txn2_mosi", c1, v.em);
        chk("res_held", res_bad[15:0], 16'd0);
        chk("res_value", {4'd0, res}, {4'd0, v.er});
        @(posedge clk); #1;
        chk("cmplt_width", {15'd0, cnv_cmplt}, 16'd0);
        chk("res_after", {4'd0, res}, {4'd0, v.er});
        chk("no_start_on_cmplt", {15'd0, SS_n}, 16'd1);
        if (hold) begin
            @(posedge clk); #1;
            chk("start_after_cmplt", {15'd0, SS_n}, 16'd0);
            strt_cnv = 1'b0;
        end
    endtask

    initial begin
        int bad_sclk, bad_ss, bad_mosi;
        vec_t v;
        tbl[0] = '{3'b101, 16'h0FFF, 16'h0ABC, 12'hABC, 16'h2800};
        tbl[1] = '{3'b001, 16'h0FFF, 16'h0001, 12'h001, 16'h0800};
        tbl[2] = '{3'b110, 16'h0000, 16'h0FFF, 12'hFFF, 16'h3000};
        tbl[3] = '{3'b000, 16'hFFFF, 16'hA555, 12'h555, 16'h0000};
        rst = 1'b1; strt_cnv = 1'b0; chnnl = '0; MISO = 1'b0;
        w1 = '0; w2 = '0; txn_sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ss_n", {15'd0, SS_n}, 16'd1);
        chk("rst_sclk", {15'd0, SCLK}, 16'd1);
        chk("rst_mosi", {15'd0, MOSI}, 16'd0);
        chk("rst_cmplt", {15'd0, cnv_cmplt}, 16'd0);
        chk("rst_res", {4'd0, res}, 16'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) run_conv(tbl[i], 1'b0, (i == 0) ? 12'h000 : tbl[i-1].er);
        bad_sclk = 0; bad_ss = 0; bad_mosi = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (SCLK !== 1'b1) bad_sclk++;
            if (SS_n !== 1'b1) bad_ss++;
            if (MOSI !== 1'b0) bad_mosi++;
        end
        chk("idle_sclk", bad_sclk[15:0], 16'd0);
        chk("idle_ss_n", bad_ss[15:0], 16'd0);
        chk("idle_mosi", bad_mosi[15:0], 16'd0);
        v = '{3'b011, 16'h1234, 16'h0765, 12'h765, 16'h1800};
        run_conv(v, 1'b1, tbl[3].er);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_res", {4'd0, res}, 16'd0);
        chk("abort_ss_n", {15'd0, SS_n}, 16'd1);
        w1 = 16'h0FFF; w2 = 16'h0FFF; txn_sel = 1'b0;
        chnnl = 3'b100; strt_cnv = 1'b1;
        @(posedge clk); #1;
        strt_cnv = 1'b0;
        chk("rst_test_start", {15'd0, SS_n}, 16'd0);
        repeat (853) @(posedge clk);
        #1;
        chk("rst_test_in_txn2", {15'd0, SS_n}, 16'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ss_n", {15'd0, SS_n}, 16'd1);
        chk("midrst_sclk", {15'd0, SCLK}, 16'd1);
        chk("midrst_mosi", {15'd0, MOSI}, 16'd0);
        chk("midrst_res", {4'd0, res}, 16'd0);
        chk("midrst_cmplt", {15'd0, cnv_cmplt}, 16'd0);
        rst = 1'b0;
        v = '{3'b010, 16'h0000, 16'h0F0F, 12'hF0F, 16'h1000};
        run_conv(v, 1'b0, 12'h000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
